int8_weight_feeder: RTL and testbench

- Column-head driver for the stationary-weight ("e") shift chain of an int8 PE column.
- Accepts a tile of ROWS weights over a valid/ready stream and drives e/e_enable so that one weight shifts into the chain per accepted beat.
- Computes the LABFT checksum weight of the tile and presents it on labft_e.
- Signals when the column holds a complete tile, and refuses new weights while the array is computing.

---
 rtl/int8_pe_pkg.sv | 14 +
 rtl/int8_checksum_acc.sv | 40 ++++
 rtl/int8_weight_feeder.sv | 133 +++++++++++++
 tb/tb_int8_weight_feeder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/int8_pe_pkg.sv
// Shared types and constants for the int8 PE column drivers.
package int8_pe_pkg;

  // Default operand width for int8 datapaths.
  localparam int DEFAULT_INPUT_BITS = 8;

  // Weight feeder load sequencing.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    LOADED = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/int8_checksum_acc.sv
// Wrapping modulo-2^W accumulator used to form the LABFT checksum weight.
// sum_o is the value the accumulator takes on the next edge, so a caller can
// capture a total that already includes the beat presented this cycle.
// clear_i together with add_en_i restarts the sum at data_i.
module int8_checksum_acc #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         add_en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] sum_o
);

  logic [W-1:0] sum_q;
  logic [W-1:0] sum_d;

  // Next sum: restart, accumulate with wrap, or hold.
  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = add_en_i ? data_i : '0;
    end else if (add_en_i) begin
      sum_d = sum_q + data_i;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_d;

endmodule

// File: rtl/int8_weight_feeder.sv
// Column-head driver for the stationary-weight shift chain of an int8 PE
// column. One accepted beat becomes one e/e_enable shift a cycle later; after
// ROWS beats the column is flagged loaded. The LABFT checksum weight (wrapping
// sum of the tile) is only built when LABFT_CHECKSUM_EN is defined; otherwise
// labft_e is tied to zero.
module int8_weight_feeder
  import int8_pe_pkg::*;
#(
  parameter int inputBits = DEFAULT_INPUT_BITS,
  parameter int ROWS      = 8,
  parameter int CNT_W     = $clog2(ROWS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [inputBits-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 compute_busy,
  input  logic                 abort,
  output logic [inputBits-1:0] e,
  output logic                 e_enable,
  output logic [inputBits-1:0] labft_e,
  output logic                 weights_loaded,
  output logic [CNT_W-1:0]     load_count
);

  feeder_state_t        state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [inputBits-1:0] e_q, e_d;
  logic                 e_en_q, e_en_d;
  logic                 loaded_q, loaded_d;

  logic accept;
  logic last_beat;

  // The chain never moves while the array computes or a cancel is pending.
  assign s_ready   = !compute_busy && !abort;
  assign accept    = s_valid && s_ready;
  assign last_beat = (state_q == LOAD) && (count_q == CNT_W'(ROWS - 1));

  // Next-state and registered output decode; abort overrides everything.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    e_d      = e_q;
    e_en_d   = 1'b0;
    loaded_d = loaded_q;
    if (abort) begin
      state_d  = IDLE;
      count_d  = '0;
      loaded_d = 1'b0;
    end else if (accept) begin
      e_d    = s_data;
      e_en_d = 1'b1;
      if (state_q == LOAD) begin
        count_d = count_q + CNT_W'(1);
        if (last_beat) begin
          state_d  = LOADED;
          loaded_d = 1'b1;
        end
      end else begin
        // A beat outside LOAD starts a fresh tile and drops the old one.
        state_d  = LOAD;
        count_d  = CNT_W'(1);
        loaded_d = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      e_q      <= '0;
      e_en_q   <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      e_q      <= e_d;
      e_en_q   <= e_en_d;
      loaded_q <= loaded_d;
    end
  end

  assign e              = e_q;
  assign e_enable       = e_en_q;
  assign weights_loaded = loaded_q;
  assign load_count     = count_q;

`ifdef LABFT_CHECKSUM_EN
  logic [inputBits-1:0] acc_sum;
  logic [inputBits-1:0] labft_q, labft_d;
  logic                 acc_clear;

  // First beat of a tile (or a cancel) restarts the running sum.
  assign acc_clear = abort || (accept && (state_q != LOAD));

  int8_checksum_acc #(
    .W(inputBits)
  ) u_acc (
    .clk      (clk),
    .rst_n    (rst),
    .clear_i  (acc_clear),
    .add_en_i (accept),
    .data_i   (s_data),
    .sum_o    (acc_sum)
  );

  // Checksum output only updates when a tile completes.
  always_comb begin
    labft_d = labft_q;
    if (accept && last_beat) begin
      labft_d = acc_sum;
    end
  end

  // Checksum output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      labft_q <= '0;
    end else begin
      labft_q <= labft_d;
    end
  end

  assign labft_e = labft_q;
`else
  assign labft_e = '0;
`endif

endmodule

// File: tb/tb_int8_weight_feeder.sv
// Directed bench for int8_weight_feeder with ROWS=4, inputBits=8.
// Expected checksums are zero unless LABFT_CHECKSUM_EN is defined.
module tb_int8_weight_feeder;

  localparam int IB   = 8;
  localparam int ROWS = 4;
  localparam int CW   = $clog2(ROWS + 1);
`ifdef LABFT_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [IB-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          compute_busy = 1'b0;
  logic          abort = 1'b0;
  logic          s_ready;
  logic [IB-1:0] e;
  logic          e_enable;
  logic [IB-1:0] labft_e;
  logic          weights_loaded;
  logic [CW-1:0] load_count;

  int total  = 0;
  int passed = 0;

  int8_weight_feeder #(
    .inputBits(IB),
    .ROWS     (ROWS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .compute_busy  (compute_busy),
    .abort         (abort),
    .e             (e),
    .e_enable      (e_enable),
    .labft_e       (labft_e),
    .weights_loaded(weights_loaded),
    .load_count    (load_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %s ok value=%0h", tag, obs);
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IB-1:0] lab(input logic [IB-1:0] v);
    return CK_EN ? v : '0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for one edge, then check the registered response.
  task automatic beat(input logic [IB-1:0] d, input int exp_cnt, input logic exp_wl,
                      input logic [IB-1:0] exp_lab);
    s_valid = 1'b1;
    s_data  = d;
    step();
    s_valid = 1'b0;
    chk("beat_e", 32'(e), 32'(d));
    chk("beat_en", 32'(e_enable), 32'(1));
    chk("beat_cnt", 32'(load_count), 32'(exp_cnt));
    chk("beat_wl", 32'(weights_loaded), 32'(exp_wl));
    chk("beat_lab", 32'(labft_e), 32'(exp_lab));
  endtask

  // Idle cycles: the chain must freeze.
  task automatic idle(input int n, input logic [IB-1:0] exp_e, input int exp_cnt);
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_en", 32'(e_enable), 32'(0));
      chk("idle_e", 32'(e), 32'(exp_e));
      chk("idle_cnt", 32'(load_count), 32'(exp_cnt));
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_e", 32'(e), 32'(0));
    chk("rst_en", 32'(e_enable), 32'(0));
    chk("rst_lab", 32'(labft_e), 32'(0));
    chk("rst_wl", 32'(weights_loaded), 32'(0));
    chk("rst_cnt", 32'(load_count), 32'(0));
    chk("rst_ready", 32'(s_ready), 32'(1));
    step();
    rst = 1'b1;
    step();

    // Back-to-back tile 01..04
    beat(8'h01, 1, 1'b0, 8'h00);
    beat(8'h02, 2, 1'b0, 8'h00);
    beat(8'h03, 3, 1'b0, 8'h00);
    beat(8'h04, 4, 1'b1, lab(8'h0A));
    idle(1, 8'h04, 4);
    chk("s1_wl_hold", 32'(weights_loaded), 32'(1));

    // Gapped tile with wrapping sum
    beat(8'h80, 1, 1'b0, lab(8'h0A));
    idle(2, 8'h80, 1);
    beat(8'h80, 2, 1'b0, lab(8'h0A));
    idle(2, 8'h80, 2);
    beat(8'hFF, 3, 1'b0, lab(8'h0A));
    idle(2, 8'hFF, 3);
    beat(8'h02, 4, 1'b1, lab(8'h01));

    // compute_busy stall after beat 2
    beat(8'h01, 1, 1'b0, lab(8'h01));
    beat(8'h02, 2, 1'b0, lab(8'h01));
    compute_busy = 1'b1;
    s_valid      = 1'b1;
    s_data       = 8'h05;
    #1;
    chk("busy_ready", 32'(s_ready), 32'(0));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("busy_en", 32'(e_enable), 32'(0));
      chk("busy_cnt", 32'(load_count), 32'(2));
      chk("busy_e", 32'(e), 32'(8'h02));
    end
    compute_busy = 1'b0;
    s_valid      = 1'b0;
    beat(8'h05, 3, 1'b0, lab(8'h01));
    beat(8'h06, 4, 1'b1, lab(8'h0E));

    // abort together with beat 3
    beat(8'h11, 1, 1'b0, lab(8'h0E));
    beat(8'h22, 2, 1'b0, lab(8'h0E));
    s_valid = 1'b1;
    s_data  = 8'h33;
    abort   = 1'b1;
    #1;
    chk("abort_ready", 32'(s_ready), 32'(0));
    step();
    s_valid = 1'b0;
    abort   = 1'b0;
    chk("abort_cnt", 32'(load_count), 32'(0));
    chk("abort_wl", 32'(weights_loaded), 32'(0));
    chk("abort_en", 32'(e_enable), 32'(0));
    chk("abort_e", 32'(e), 32'(8'h22));
    chk("abort_lab", 32'(labft_e), 32'(lab(8'h0E)));

    // Full tile, then a new tile drops weights_loaded
    beat(8'h01, 1, 1'b0, lab(8'h0E));
    beat(8'h01, 2, 1'b0, lab(8'h0E));
    beat(8'h01, 3, 1'b0, lab(8'h0E));
    beat(8'h01, 4, 1'b1, lab(8'h04));
    beat(8'h10, 1, 1'b0, lab(8'h04));
    beat(8'h20, 2, 1'b0, lab(8'h04));
    beat(8'h30, 3, 1'b0, lab(8'h04));
    beat(8'h40, 4, 1'b1, lab(8'hA0));

    // Asynchronous reset mid-load
    beat(8'h07, 1, 1'b0, lab(8'hA0));
    beat(8'h08, 2, 1'b0, lab(8'hA0));
    #2;
    rst = 1'b0;
    #1;
    chk("arst_e", 32'(e), 32'(0));
    chk("arst_en", 32'(e_enable), 32'(0));
    chk("arst_cnt", 32'(load_count), 32'(0));
    chk("arst_wl", 32'(weights_loaded), 32'(0));
    chk("arst_lab", 32'(labft_e), 32'(0));
    step();
    rst = 1'b1;
    beat(8'h05, 1, 1'b0, 8'h00);
    beat(8'h05, 2, 1'b0, 8'h00);
    beat(8'h05, 3, 1'b0, 8'h00);
    beat(8'h05, 4, 1'b1, lab(8'h14));
    idle(1, 8'h05, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
